// File: rtl/fp_writeback_arbiter.sv
// FP register-file write-port arbiter: FLW load returns always win, FPU results are queued.
// Optional sticky exception flags are enabled by defining FP_WB_FFLAGS_EN.
module fp_writeback_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_ld_valid,
  input  logic [ADDR_W-1:0]             i_ld_addr,
  input  logic [DATA_W-1:0]             i_ld_data,
  input  logic                          i_fpu_valid,
  output logic                          o_fpu_ready,
  input  logic [ADDR_W-1:0]             i_fpu_addr,
  input  logic [DATA_W-1:0]             i_fpu_data,
  input  logic [4:0]                    i_fpu_fflags,
  output logic                          o_write_fp,
  output logic [ADDR_W-1:0]             o_write_addr,
  output logic [DATA_W-1:0]             o_write_data,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic [4:0]                    o_fflags,
  input  logic                          i_fflags_clr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LOAD,
    SRC_FIFO,
    SRC_BYPASS
  } src_t;

  src_t              src;
  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic              accept;
  logic              push;
  logic              pop;

  // Ready comes only from the registered count, never from the valid inputs.
  assign o_fpu_ready  = (count < CW'(FIFO_DEPTH));
  assign o_fifo_count = count;
  assign accept       = i_fpu_valid && o_fpu_ready;

  always_comb begin
    src = SRC_NONE;
    if (i_ld_valid)
      src = SRC_LOAD;
    else if (count != '0)
      src = SRC_FIFO;
    else if (accept)
      src = SRC_BYPASS;
  end

  assign pop  = (src == SRC_FIFO);
  assign push = accept && (src != SRC_BYPASS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= i_fpu_addr;
      data_mem[wr_ptr] <= i_fpu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_write_fp   <= 1'b0;
      o_write_addr <= '0;
      o_write_data <= '0;
    end else begin
      case (src)
        SRC_LOAD: begin
          o_write_fp   <= 1'b1;
          o_write_addr <= i_ld_addr;
          o_write_data <= i_ld_data;
        end
        SRC_FIFO: begin
          o_write_fp   <= 1'b1;
          o_write_addr <= addr_mem[rd_ptr];
          o_write_data <= data_mem[rd_ptr];
        end
        SRC_BYPASS: begin
          o_write_fp   <= 1'b1;
          o_write_addr <= i_fpu_addr;
          o_write_data <= i_fpu_data;
        end
        default: o_write_fp <= 1'b0;
      endcase
    end
  end

`ifdef FP_WB_FFLAGS_EN
  logic [4:0] flag_mem [FIFO_DEPTH];
  logic [4:0] new_flags;

  // Flags accumulate when the result reaches the register file, not at acceptance.
  always_comb begin
    new_flags = '0;
    case (src)
      SRC_FIFO:   new_flags = flag_mem[rd_ptr];
      SRC_BYPASS: new_flags = i_fpu_fflags;
      default:    new_flags = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      flag_mem[wr_ptr] <= i_fpu_fflags;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      o_fflags <= '0;
    else if (i_fflags_clr)
      o_fflags <= new_flags;
    else
      o_fflags <= o_fflags | new_flags;
  end
`else
  logic unused_fflags;

  assign o_fflags      = '0;
  assign unused_fflags = ^{i_fflags_clr, i_fpu_fflags};
`endif

endmodule

// File: tb/tb_fp_writeback_arbiter.sv
// Scoreboard bench for fp_writeback_arbiter: loads and FPU results are queued as expected
// writes; a negedge monitor pops and compares each register-file write.
module tb_fp_writeback_arbiter;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int FIFO_DEPTH = 2;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;
  localparam int EW         = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_ld_valid = 1'b0;
  logic [ADDR_W-1:0] i_ld_addr = '0;
  logic [DATA_W-1:0] i_ld_data = '0;
  logic              i_fpu_valid = 1'b0;
  logic              o_fpu_ready;
  logic [ADDR_W-1:0] i_fpu_addr = '0;
  logic [DATA_W-1:0] i_fpu_data = '0;
  logic [4:0]        i_fpu_fflags = '0;
  logic              o_write_fp;
  logic [ADDR_W-1:0] o_write_addr;
  logic [DATA_W-1:0] o_write_data;
  logic [CW-1:0]     o_fifo_count;
  logic [4:0]        o_fflags;
  logic              i_fflags_clr = 1'b0;

  fp_writeback_arbiter #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_ld_valid  (i_ld_valid),
    .i_ld_addr   (i_ld_addr),
    .i_ld_data   (i_ld_data),
    .i_fpu_valid (i_fpu_valid),
    .o_fpu_ready (o_fpu_ready),
    .i_fpu_addr  (i_fpu_addr),
    .i_fpu_data  (i_fpu_data),
    .i_fpu_fflags(i_fpu_fflags),
    .o_write_fp  (o_write_fp),
    .o_write_addr(o_write_addr),
    .o_write_data(o_write_data),
    .o_fifo_count(o_fifo_count),
    .o_fflags    (o_fflags),
    .i_fflags_clr(i_fflags_clr)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passed = 0;
  logic [EW-1:0] ld_q[$];
  logic [EW-1:0] fpu_q[$];
  logic [EW-1:0] mon_exp;
  logic          ld_prev;

`ifdef FP_WB_FFLAGS_EN
  localparam logic FFLAGS_ON = 1'b1;
`else
  localparam logic FFLAGS_ON = 1'b0;
`endif

  // A load driven last cycle must be the write now; otherwise the oldest accepted FPU result.
  always @(posedge clk or posedge rst) begin
    if (rst) ld_prev <= 1'b0;
    else     ld_prev <= i_ld_valid;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (o_write_fp) begin
        if (ld_prev) mon_exp = (ld_q.size() > 0) ? ld_q.pop_front() : 'x;
        else         mon_exp = (fpu_q.size() > 0) ? fpu_q.pop_front() : 'x;
        checks++;
        if ({o_write_addr, o_write_data} !== mon_exp)
          $display("FAIL write_%s: got f%0d=%h expected %h", ld_prev ? "load" : "fpu",
                   o_write_addr, o_write_data, mon_exp);
        else
          passed++;
      end else if (ld_prev) begin
        checks++;
        $display("FAIL load_write_missing: o_write_fp=0 expected 1");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with the current inputs; records which results should be written later.
  task automatic cycle(output logic acc);
    acc = i_fpu_valid && o_fpu_ready;
    if (i_ld_valid) ld_q.push_back({i_ld_addr, i_ld_data});
    tick();
    if (acc) fpu_q.push_back({i_fpu_addr, i_fpu_data});
  endtask

  task automatic idle_inputs();
    i_ld_valid   = 1'b0;
    i_fpu_valid  = 1'b0;
    i_fpu_fflags = '0;
    i_fflags_clr = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && (ld_q.size() + fpu_q.size()) != 0; i++) tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({o_write_fp, o_write_addr, o_write_data} !== '0)
      $display("FAIL reset_write: got fp=%b f%0d=%h expected all 0", o_write_fp, o_write_addr, o_write_data);
    else passed++;
    checks++;
    if (o_fifo_count !== '0) $display("FAIL reset_count: got %0d expected 0", o_fifo_count);
    else passed++;
    checks++;
    if (o_fflags !== 5'b0) $display("FAIL reset_fflags: got %b expected 00000", o_fflags);
    else passed++;
    rst = 1'b0;
    #1;
    checks++;
    if (o_fpu_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", o_fpu_ready);
    else passed++;
  endtask

  task automatic test_bypass();
    logic acc;
    i_fpu_valid = 1'b1; i_fpu_addr = 5'd3; i_fpu_data = 32'h3F800000;
    cycle(acc);
    idle_inputs();
    checks++;
    if (o_write_fp !== 1'b1) $display("FAIL bypass_latency: o_write_fp=%b expected 1", o_write_fp);
    else passed++;
    checks++;
    if (o_fifo_count !== '0) $display("FAIL bypass_count: got %0d expected 0", o_fifo_count);
    else passed++;
    wait_drain();
  endtask

  task automatic test_collision();
    logic acc;
    i_ld_valid  = 1'b1; i_ld_addr  = 5'd1; i_ld_data  = 32'h40000000;
    i_fpu_valid = 1'b1; i_fpu_addr = 5'd2; i_fpu_data = 32'h40400000;
    cycle(acc);
    idle_inputs();
    checks++;
    if (o_fifo_count !== CW'(1)) $display("FAIL collision_count1: got %0d expected 1", o_fifo_count);
    else passed++;
    cycle(acc);
    checks++;
    if (o_fifo_count !== '0) $display("FAIL collision_count0: got %0d expected 0", o_fifo_count);
    else passed++;
    wait_drain();
  endtask

  task automatic test_full();
    logic acc;
    int k = 0;
    for (int c = 0; c < 6; c++) begin
      i_ld_valid  = (c < 3);
      i_ld_addr   = ADDR_W'(10 + c);
      i_ld_data   = DATA_W'(32'h1000 + c);
      i_fpu_valid = (k < 3);
      i_fpu_addr  = ADDR_W'(20 + k);
      i_fpu_data  = DATA_W'(32'h2000 + k);
      if (c == 2) begin
        checks++;
        if ({o_fpu_ready, o_fifo_count} !== {1'b0, CW'(2)})
          $display("FAIL full_ready: got ready=%b count=%0d expected ready=0 count=2", o_fpu_ready, o_fifo_count);
        else passed++;
      end
      cycle(acc);
      if (acc) k++;
    end
    idle_inputs();
    wait_drain();
    checks++;
    if (k != 3) $display("FAIL full_accepts: got %0d expected 3", k);
    else passed++;
    checks++;
    if ({o_fpu_ready, o_fifo_count} !== {1'b1, CW'(0)})
      $display("FAIL full_recover: got ready=%b count=%0d expected ready=1 count=0", o_fpu_ready, o_fifo_count);
    else passed++;
  endtask

  task automatic test_push_pop();
    logic acc;
    i_ld_valid  = 1'b1; i_ld_addr  = 5'd7; i_ld_data  = 32'h7;
    i_fpu_valid = 1'b1; i_fpu_addr = 5'd8; i_fpu_data = 32'h8;
    cycle(acc);
    i_ld_valid  = 1'b0;
    i_fpu_addr  = 5'd0; i_fpu_data = 32'hCAFE0009;
    cycle(acc);
    idle_inputs();
    checks++;
    if ({o_write_fp, o_fifo_count} !== {1'b1, CW'(1)})
      $display("FAIL push_pop: got fp=%b count=%0d expected fp=1 count=1", o_write_fp, o_fifo_count);
    else passed++;
    wait_drain();
    checks++;
    if (o_fifo_count !== '0) $display("FAIL push_pop_drain: got %0d expected 0", o_fifo_count);
    else passed++;
  endtask

  task automatic test_fflags();
    logic acc;
    i_fpu_valid = 1'b1; i_fpu_addr = 5'd4; i_fpu_data = 32'h4; i_fpu_fflags = 5'b00001;
    cycle(acc);
    checks++;
    if (o_fflags !== (FFLAGS_ON ? 5'b00001 : 5'b0)) $display("FAIL fflags_first: got %b", o_fflags);
    else passed++;
    i_fpu_addr = 5'd5; i_fpu_data = 32'h5; i_fpu_fflags = 5'b10000;
    cycle(acc);
    idle_inputs();
    checks++;
    if (o_fflags !== (FFLAGS_ON ? 5'b10001 : 5'b0))
      $display("FAIL fflags_sticky: got %b expected %b", o_fflags, FFLAGS_ON ? 5'b10001 : 5'b0);
    else passed++;
    i_fflags_clr = 1'b1;
    cycle(acc);
    checks++;
    if (o_fflags !== 5'b0) $display("FAIL fflags_clear: got %b expected 00000", o_fflags);
    else passed++;
    i_fpu_valid = 1'b1; i_fpu_addr = 5'd6; i_fpu_data = 32'h6; i_fpu_fflags = 5'b00100;
    cycle(acc);
    idle_inputs();
    checks++;
    if (o_fflags !== (FFLAGS_ON ? 5'b00100 : 5'b0))
      $display("FAIL fflags_clear_update: got %b expected %b", o_fflags, FFLAGS_ON ? 5'b00100 : 5'b0);
    else passed++;
    wait_drain();
  endtask

  task automatic test_reset_mid_burst();
    logic acc;
    i_ld_valid  = 1'b1; i_ld_addr  = 5'd11; i_ld_data  = 32'hAAAA;
    i_fpu_valid = 1'b1; i_fpu_addr = 5'd12; i_fpu_data = 32'hBBBB;
    cycle(acc);
    i_fpu_addr = 5'd13; i_fpu_data = 32'hCCCC;
    cycle(acc);
    checks++;
    if (o_fifo_count !== CW'(2)) $display("FAIL midrst_queued: got %0d expected 2", o_fifo_count);
    else passed++;
    rst = 1'b1;
    idle_inputs();
    ld_q.delete();
    fpu_q.delete();
    tick();
    checks++;
    if ({o_write_fp, o_fifo_count, o_fpu_ready} !== {1'b0, CW'(0), 1'b1})
      $display("FAIL midrst_state: got fp=%b count=%0d ready=%b expected 0/0/1", o_write_fp, o_fifo_count, o_fpu_ready);
    else passed++;
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({o_write_fp, o_fifo_count} !== {1'b0, CW'(0)})
      $display("FAIL midrst_discard: got fp=%b count=%0d expected 0/0", o_write_fp, o_fifo_count);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_collision();
    test_full();
    test_push_pop();
    test_fflags();
    test_reset_mid_burst();
    checks++;
    if ((ld_q.size() + fpu_q.size()) != 0)
      $display("FAIL scoreboard_empty: %0d writes outstanding expected 0", ld_q.size() + fpu_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
